// File: rtl/nonce_sweeper.sv
// rtl/nonce_sweeper.sv - nonce sweep controller driving a double-SHA-256 engine
// Optional feature macro: NONCE_SWEEPER_BYTESWAP_EN (byte-reverse engine hash before compare)
module nonce_sweeper #(
    parameter int unsigned CORE_RST_CYCLES = 2,
    parameter int unsigned TIMEOUT_CYCLES  = 4095
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         start_i,
    input  logic         stop_i,
    input  logic [607:0] header_i,
    input  logic [31:0]  nonce_start_i,
    input  logic [31:0]  nonce_end_i,
    input  logic [255:0] target_i,
    output logic         core_rst_o,
    output logic [639:0] block_info_o,
    input  logic         core_complete_i,
    input  logic [255:0] core_hash_i,
    output logic         busy_o,
    output logic         found_o,
    output logic         exhausted_o,
    output logic         timeout_o,
    output logic [31:0]  nonce_o,
    output logic [255:0] hash_o,
    output logic [31:0]  attempts_o
);

    localparam int unsigned     WD_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]      RST_LAST = 4'(CORE_RST_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT, S_CHECK} state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [607:0]   r_header;
    logic [31:0]    r_nonce_end;
    logic [255:0]   r_target;
    logic [31:0]    r_nonce;
    logic [3:0]     r_rst_cnt;
    logic [WD_W-1:0] r_wdog;
    logic [639:0]   r_block_info;
    logic           r_found;
    logic           r_exhausted;
    logic           r_timeout;
    logic [31:0]    r_nonce_o;
    logic [255:0]   r_hash_o;
    logic [31:0]    r_attempts;

    logic           w_begin;
    logic           w_empty;
    logic           w_check;
    logic           w_hit;
    logic           w_last;
    logic           w_timeout;
    logic           w_advance;
    logic           w_pass;
    logic [255:0]   w_hash;

`ifdef NONCE_SWEEPER_BYTESWAP_EN
    // Reverse byte order of the engine hash (byte 0 <-> byte 31)
    always_comb begin
        w_hash = '0;
        for (int b = 0; b < 32; b++) begin
            w_hash[8*b +: 8] = core_hash_i[8*(31-b) +: 8];
        end
    end
`else
    assign w_hash = core_hash_i;
`endif

    assign w_pass = (w_hash <= r_target);

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and per-cycle control strobes
    always_comb begin
        w_state_nxt = r_state;
        w_begin     = 1'b0;
        w_empty     = 1'b0;
        w_check     = 1'b0;
        w_hit       = 1'b0;
        w_last      = 1'b0;
        w_timeout   = 1'b0;
        w_advance   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start_i) begin
                    if (nonce_start_i > nonce_end_i) begin
                        w_empty = 1'b1;
                    end else begin
                        w_begin     = 1'b1;
                        w_state_nxt = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                if (r_rst_cnt == RST_LAST) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (stop_i) begin
                    w_state_nxt = S_IDLE;
                end else if (core_complete_i) begin
                    w_state_nxt = S_CHECK;
                end else if (r_wdog == WD_LAST) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            S_CHECK: begin
                w_check = 1'b1;
                if (w_pass) begin
                    w_hit       = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (r_nonce == r_nonce_end) begin
                    // equality test ends the range, so an end of FFFFFFFF never wraps
                    w_last      = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (stop_i) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_advance   = 1'b1;
                    w_state_nxt = S_LOAD;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath: latched job, counters, header image and sticky results
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_header     <= '0;
            r_nonce_end  <= '0;
            r_target     <= '0;
            r_nonce      <= '0;
            r_rst_cnt    <= '0;
            r_wdog       <= '0;
            r_block_info <= '0;
            r_found      <= 1'b0;
            r_exhausted  <= 1'b0;
            r_timeout    <= 1'b0;
            r_nonce_o    <= '0;
            r_hash_o     <= '0;
            r_attempts   <= '0;
        end else begin
            if (w_begin || w_empty) begin
                r_header    <= header_i;
                r_nonce_end <= nonce_end_i;
                r_target    <= target_i;
                r_nonce     <= nonce_start_i;
                r_found     <= 1'b0;
                r_exhausted <= w_empty;
                r_timeout   <= 1'b0;
                r_attempts  <= '0;
            end
            if (w_begin) begin
                r_block_info <= {header_i, nonce_start_i};
            end

            // counters sit at zero outside their own state so each entry starts fresh
            r_rst_cnt <= (r_state == S_LOAD && w_state_nxt == S_LOAD) ? r_rst_cnt + 4'd1 : 4'd0;
            r_wdog    <= (r_state == S_WAIT) ? r_wdog + 1'b1 : '0;

            if (w_check) begin
                r_nonce_o <= r_nonce;
                r_hash_o  <= w_hash;
                if (r_attempts != 32'hFFFF_FFFF) begin
                    r_attempts <= r_attempts + 32'd1;
                end
            end
            if (w_hit) begin
                r_found <= 1'b1;
            end
            if (w_last) begin
                r_exhausted <= 1'b1;
            end
            if (w_timeout) begin
                r_timeout <= 1'b1;
            end
            if (w_advance) begin
                r_nonce      <= r_nonce + 32'd1;
                r_block_info <= {r_header, r_nonce + 32'd1};
            end
        end
    end

    // engine is held in reset whenever idle or loading a new header
    assign core_rst_o   = (r_state == S_IDLE) || (r_state == S_LOAD);
    assign busy_o       = (r_state != S_IDLE);
    assign block_info_o = r_block_info;
    assign found_o      = r_found;
    assign exhausted_o  = r_exhausted;
    assign timeout_o    = r_timeout;
    assign nonce_o      = r_nonce_o;
    assign hash_o       = r_hash_o;
    assign attempts_o   = r_attempts;

endmodule

// File: tb/tb_nonce_sweeper.sv
// tb/tb_nonce_sweeper.sv - directed self-checking bench for nonce_sweeper
module tb_nonce_sweeper;

    localparam int RST_CYC = 2;
`ifdef NONCE_SWEEPER_BYTESWAP_EN
    localparam logic [255:0] PASS_RAW = {8'h01, 248'h0};
`else
    localparam logic [255:0] PASS_RAW = 256'h1;
`endif

    logic         clk = 1'b0;
    logic         rst_ni;
    logic         start_i, stop_i;
    logic [607:0] header_i;
    logic [31:0]  nonce_start_i, nonce_end_i;
    logic [255:0] target_i;
    logic         core_rst_o;
    logic [639:0] block_info_o;
    logic         core_complete_i;
    logic [255:0] core_hash_i;
    logic         busy_o, found_o, exhausted_o, timeout_o;
    logic [31:0]  nonce_o, attempts_o;
    logic [255:0] hash_o;

    logic         to_start;
    logic         to_core_rst, to_busy, to_found, to_exhausted, to_timeout;
    logic [639:0] to_block_info;
    logic [31:0]  to_nonce, to_attempts;
    logic [255:0] to_hash;

    logic         pass_en;
    logic [31:0]  pass_nonce;
    int           eng_cnt;
    int           n_checks = 0;
    int           n_fail = 0;
    int           falls, bad, n;

    always #5 clk = ~clk;

    nonce_sweeper u_dut (
        .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i), .stop_i(stop_i),
        .header_i(header_i), .nonce_start_i(nonce_start_i), .nonce_end_i(nonce_end_i),
        .target_i(target_i), .core_rst_o(core_rst_o), .block_info_o(block_info_o),
        .core_complete_i(core_complete_i), .core_hash_i(core_hash_i),
        .busy_o(busy_o), .found_o(found_o), .exhausted_o(exhausted_o),
        .timeout_o(timeout_o), .nonce_o(nonce_o), .hash_o(hash_o), .attempts_o(attempts_o)
    );

    nonce_sweeper #(.CORE_RST_CYCLES(2), .TIMEOUT_CYCLES(64)) u_dut_to (
        .clk_i(clk), .rst_ni(rst_ni), .start_i(to_start), .stop_i(1'b0),
        .header_i(header_i), .nonce_start_i(32'd0), .nonce_end_i(32'd9),
        .target_i(256'hFF), .core_rst_o(to_core_rst), .block_info_o(to_block_info),
        .core_complete_i(1'b0), .core_hash_i(256'h0),
        .busy_o(to_busy), .found_o(to_found), .exhausted_o(to_exhausted),
        .timeout_o(to_timeout), .nonce_o(to_nonce), .hash_o(to_hash), .attempts_o(to_attempts)
    );

    // engine model: completes 100 cycles after its reset drops, passing hash only on pass_nonce
    always @(posedge clk) begin
        if (core_rst_o) begin
            eng_cnt         <= 0;
            core_complete_i <= 1'b0;
        end else if (!core_complete_i) begin
            if (eng_cnt == 99) core_complete_i <= 1'b1;
            eng_cnt <= eng_cnt + 1;
        end
    end
    assign core_hash_i = (pass_en && block_info_o[31:0] == pass_nonce) ? PASS_RAW : {256{1'b1}};

    task automatic chk(input string tag, input logic [639:0] got, input logic [639:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic go(input logic [31:0] a, input logic [31:0] b, input logic [255:0] t);
        @(negedge clk);
        nonce_start_i = a;
        nonce_end_i   = b;
        target_i      = t;
        start_i       = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget, output int f, output int bd);
        int   run;
        logic prev;
        run = 0; prev = 1'b1; f = 0; bd = 0;
        for (int i = 0; i < budget && busy_o; i++) begin
            if (core_rst_o) begin
                run++;
            end else begin
                if (prev) begin
                    f++;
                    if (run != RST_CYC) bd++;
                end
                run = 0;
            end
            prev = core_rst_o;
            @(negedge clk);
        end
        chk({tag, "_done"}, 640'(busy_o), 640'd0);
    endtask

    initial begin
        rst_ni = 1'b0; start_i = 1'b0; stop_i = 1'b0; to_start = 1'b0;
        header_i = {19{32'hDEADBEEF}};
        nonce_start_i = '0; nonce_end_i = '0; target_i = '0;
        pass_en = 1'b0; pass_nonce = '0;
        repeat (3) @(negedge clk);
        chk("rst_core_rst", 640'(core_rst_o), 640'd1);
        chk("rst_busy", 640'(busy_o), 640'd0);
        chk("rst_block", block_info_o, 640'd0);
        chk("rst_flags", 640'({found_o, exhausted_o, timeout_o}), 640'd0);
        chk("rst_attempts", 640'(attempts_o), 640'd0);
        rst_ni = 1'b1;

        // hit on nonce 5 in range 0..9
        pass_en = 1'b1; pass_nonce = 32'd5;
        go(32'd0, 32'd9, 256'hFF);
        chk("t1_load_busy", 640'(busy_o), 640'd1);
        chk("t1_block", block_info_o, {header_i, 32'd0});
        wait_done("t1", 3000, falls, bad);
        chk("t1_found", 640'(found_o), 640'd1);
        chk("t1_exh", 640'(exhausted_o), 640'd0);
        chk("t1_nonce", 640'(nonce_o), 640'd5);
        chk("t1_attempts", 640'(attempts_o), 640'd6);
        chk("t1_hash", 640'(hash_o), 640'd1);
        chk("t1_core_rst", 640'(core_rst_o), 640'd1);

        // hash exactly equal to target passes
        go(32'd5, 32'd5, 256'h1);
        wait_done("teq", 1000, falls, bad);
        chk("teq_found", 640'(found_o), 640'd1);
        chk("teq_attempts", 640'(attempts_o), 640'd1);

        // no hit in range 3..7
        pass_en = 1'b0;
        go(32'd3, 32'd7, 256'hFF);
        wait_done("t2", 3000, falls, bad);
        chk("t2_exh", 640'(exhausted_o), 640'd1);
        chk("t2_found", 640'(found_o), 640'd0);
        chk("t2_nonce", 640'(nonce_o), 640'd7);
        chk("t2_attempts", 640'(attempts_o), 640'd5);
        chk("t2_rst_pulses", 640'(falls), 640'd5);
        chk("t2_rst_len_bad", 640'(bad), 640'd0);

        // top-of-range: must stop at FFFFFFFF without wrapping
        go(32'hFFFF_FFFE, 32'hFFFF_FFFF, 256'hFF);
        wait_done("t3", 1000, falls, bad);
        chk("t3_exh", 640'(exhausted_o), 640'd1);
        chk("t3_attempts", 640'(attempts_o), 640'd2);
        chk("t3_nonce", 640'(nonce_o), 640'hFFFF_FFFF);

        // empty range: immediate exhaust, no attempt
        go(32'd5, 32'd3, 256'hFF);
        chk("te_exh", 640'(exhausted_o), 640'd1);
        chk("te_busy", 640'(busy_o), 640'd0);
        chk("te_attempts", 640'(attempts_o), 640'd0);

        // stop mid-WAIT on attempt 3
        go(32'd0, 32'd9, 256'hFF);
        n = 0;
        while (!(attempts_o == 32'd2 && !core_rst_o) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        repeat (10) @(negedge clk);
        chk("ts_pre_busy", 640'(busy_o), 640'd1);
        stop_i = 1'b1;
        @(negedge clk);
        stop_i = 1'b0;
        chk("ts_busy", 640'(busy_o), 640'd0);
        chk("ts_core_rst", 640'(core_rst_o), 640'd1);
        chk("ts_flags", 640'({found_o, exhausted_o, timeout_o}), 640'd0);
        chk("ts_attempts", 640'(attempts_o), 640'd2);

        // hung engine on the 64-cycle watchdog instance
        @(negedge clk);
        to_start = 1'b1;
        @(negedge clk);
        to_start = 1'b0;
        n = 0;
        while (to_core_rst && n < 20) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        while (!to_timeout && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("to_cycles", 640'(n), 640'd64);
        chk("to_flag", 640'(to_timeout), 640'd1);
        chk("to_core_rst", 640'(to_core_rst), 640'd1);
        chk("to_busy", 640'(to_busy), 640'd0);
        chk("to_attempts", 640'(to_attempts), 640'd0);

        // async reset during LOAD of attempt 2
        go(32'd0, 32'd9, 256'hFF);
        n = 0;
        while (!(attempts_o == 32'd1 && core_rst_o && busy_o) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("tr_pre_block", block_info_o, {header_i, 32'd1});
        rst_ni = 1'b0;
        #1;
        chk("tr_busy", 640'(busy_o), 640'd0);
        chk("tr_core_rst", 640'(core_rst_o), 640'd1);
        chk("tr_block", block_info_o, 640'd0);
        chk("tr_hash", 640'(hash_o), 640'd0);
        chk("tr_attempts", 640'(attempts_o), 640'd0);
        @(negedge clk);
        rst_ni = 1'b1;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/nonce_sweeper.md
Name: nonce_sweeper

Overview:
- Front-end controller that drives the double-SHA-256 engine (640-bit `block_info` in; `complete` / 256-bit `hash` out).
- Builds each 80-byte header from a 608-bit header prefix plus a 32-bit nonce.
- Restarts the engine once per nonce, waits for `complete`, then compares the hash against a 256-bit target.
- Sweeps nonces until a hash meets target, the range is exhausted, stop is requested, or the engine hangs.

Parameters:
- CORE_RST_CYCLES, 2: cycles `core_rst_o` is held high per attempt; legal range 1..15.
- TIMEOUT_CYCLES, 4095: maximum cycles spent in WAIT before the engine is declared hung; must be nonzero.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- start_i  in  1  one-cycle pulse; begins a sweep; ignored while busy_o=1
- stop_i  in  1  level; aborts the sweep at the next CHECK or WAIT cycle
- header_i  in  608  header prefix; sampled on start
- nonce_start_i  in  32  first nonce; sampled on start
- nonce_end_i  in  32  last nonce, inclusive; sampled on start
- target_i  in  256  hash passes when hash <= target (unsigned); sampled on start
- core_rst_o  out  1  active-high synchronous reset to the engine
- block_info_o  out  640  {header, nonce}; nonce occupies [31:0]
- core_complete_i  in  1  engine complete; sticky until engine reset
- core_hash_i  in  256  engine hash; valid while core_complete_i=1
- busy_o  out  1  sweep in progress
- found_o  out  1  sticky; hash met target
- exhausted_o  out  1  sticky; range finished with no hit
- timeout_o  out  1  sticky; engine hang detected
- nonce_o  out  32  nonce of the last checked attempt
- hash_o  out  256  hash of the last checked attempt (after optional swap)
- attempts_o  out  32  number of completed compares; saturates at 2^32-1

Behaviour:
- Reset (async, rst_ni=0):
  - State IDLE; all sticky flags, nonce_o, hash_o, attempts_o and internal registers cleared.
  - core_rst_o=1 (engine held in reset while idle); block_info_o=0.
- IDLE: on start_i=1:
  - Latch header, range and target.
  - nonce := nonce_start_i; clear found_o, exhausted_o, timeout_o and attempts_o.
  - busy_o=1; go to LOAD.
  - If nonce_start_i > nonce_end_i: exhausted_o=1 immediately, no attempt is made, return to IDLE.
- LOAD:
  - block_info_o = {header, nonce}, updated on entry and held stable until the next LOAD.
  - core_rst_o=1 for exactly CORE_RST_CYCLES cycles, then 0; go to WAIT with the watchdog cleared.
- WAIT:
  - Watchdog increments each cycle. When core_complete_i=1, go to CHECK.
  - If the watchdog reaches TIMEOUT_CYCLES first: timeout_o=1, core_rst_o=1, busy_o=0, go to IDLE.
  - stop_i=1 in WAIT: core_rst_o=1, busy_o=0, go to IDLE with no flag set.
- CHECK (one cycle):
  - Register nonce_o=nonce, hash_o=(swapped) hash, attempts_o+1 (saturating).
  - If hash <= target: found_o=1, go to IDLE.
  - Else if nonce == nonce_end_i: exhausted_o=1, go to IDLE.
  - Else if stop_i: go to IDLE.
  - Else nonce+1, go to LOAD.
  - Priority: found > exhausted > stop.
  - nonce_end_i=FFFFFFFF must terminate via the equality test, never by wrap-around.
- Timing:
  - Per-attempt overhead is CORE_RST_CYCLES + 1 (CHECK) cycles plus engine latency.
  - start-to-first-LOAD latency is 1 cycle.
- Any return to IDLE asserts core_rst_o=1 in the same cycle.
- busy_o falls in the same cycle the terminating flag rises.
- A start_i coincident with termination is ignored.

Optional Feature:
- Macro: NONCE_SWEEPER_BYTESWAP_EN.
- Defined: the 32 bytes of core_hash_i are reversed (byte 0 <-> byte 31) before the compare and before hash_o, matching little-endian target convention.
- Undefined: hash is used unmodified.

Test Plan:
- Engine model completes after 100 cycles; hash 0x00..01 on nonce 5 only; target 0x00..FF; range 0..9 -> found_o=1, nonce_o=5, attempts_o=6, busy_o=0.
- Same setup, no passing hash; range 3..7 -> exhausted_o=1, nonce_o=7, attempts_o=5; core_rst_o pulses exactly 5 times, each CORE_RST_CYCLES long.
- Range FFFFFFFE..FFFFFFFF, never passes -> exhausted_o=1 after 2 attempts, no wrap to nonce 0.
- Engine never completes, TIMEOUT_CYCLES=64 -> timeout_o=1 exactly 64 cycles after core_rst_o deasserts; core_rst_o=1.
- stop_i raised mid-WAIT on attempt 3 -> IDLE within 1 cycle, all flags 0, attempts_o=2; rst_ni pulsed mid-LOAD -> all outputs return to reset values immediately.
- With NONCE_SWEEPER_BYTESWAP_EN: hash 0x01 followed by 31 zero bytes, target 0x00..01 -> found_o=1, hash_o=0x00..01.
